// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
package mips_ctrl_pkg;

  localparam int unsigned OP_W       = 6;
  localparam int unsigned WAIT_CNT_W = 4;

  localparam logic [OP_W-1:0] OP_R    = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OP_W-1:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } ctrl_state_t;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that access the shared memory and stall on mem_ready
  function automatic logic is_mem_state(input ctrl_state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating count of consecutive memory-stall cycles with a sticky timeout flag.
module mem_wait_timer
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_wait,
  output logic o_timeout
);

  logic [WAIT_CNT_W-1:0] r_cnt;
  logic                  r_timeout;
  logic                  w_hit;

  // Any cycle that is not a stall restarts the count, so every memory state starts from zero
  assign w_hit = (32'(r_cnt) + 32'd1) >= MEM_WAIT_MAX;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (!i_wait) begin
        r_cnt <= '0;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + WAIT_CNT_W'(1);
      end
      if (i_wait && w_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign o_timeout = r_timeout;

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath sharing one memory.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] Op,
  input  logic            Zero,
  input  logic            mem_ready,
  output logic            IDSel,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            RegDst,
  output logic            MemtoReg,
  output logic            RegWrite,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic [1:0]      PCSrc,
  output logic            PCWrite,
  output logic            illegal_op,
  output logic            mem_timeout
);

  ctrl_state_t r_state;
  logic        w_wait;
  logic        w_known_op;

  assign w_known_op = Op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  assign w_wait     = is_mem_state(r_state) && !mem_ready;

  // State sequencing; memory states hold until mem_ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (Op)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_R:         r_state <= S_EXEC;
            OP_BEQ:       r_state <= S_BRANCH;
            OP_ADDI:      r_state <= S_ADDIEX;
            OP_J:         r_state <= S_JUMP;
            default:      r_state <= S_FETCH;
          endcase
        end
        S_MEMADR: r_state <= (Op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (mem_ready) r_state <= S_MEMWB;
        S_MEMWR:  if (mem_ready) r_state <= S_FETCH;
        S_EXEC:   r_state <= S_ALUWB;
        S_ADDIEX: r_state <= S_ADDIWB;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  // Moore decode; FETCH enables and BRANCH PCWrite also look at mem_ready / Zero
  always_comb begin
    IDSel      = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REGB;
    ALUOp      = ALUOP_ADD;
    PCSrc      = PCSRC_ALU;
    PCWrite    = 1'b0;
    illegal_op = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB    = SRCB_IMM_SH2;
        illegal_op = !w_known_op;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: IDSel = 1'b1;
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IDSel    = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_SUB;
        PCSrc   = PCSRC_ALUOUT;
        PCWrite = Zero;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_JUMP: begin
        PCSrc   = PCSRC_JUMP;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
    // Reset blocks every write immediately, before the state register is cleared
    if (!rst_n) begin
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      PCWrite    = 1'b0;
      illegal_op = 1'b0;
    end
  end

  mem_wait_timer #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_mem_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wait   (w_wait),
    .o_timeout(mem_timeout)
  );

endmodule
